// File: rtl/axil_master.sv
// AXI4-Lite master engine.
//
// Turns single-cycle read/write start pulses from the pipeline into AXI4-Lite
// transactions. The read path and the write path are independent FSMs, so one
// read and one write may be in flight at the same time. Each path returns a
// one-cycle DONE pulse plus held result data / error flags.
//
// Ports:
//   CLK, RST_N                    clock, asynchronous active-low reset
//   AXIL_START_READ/_WRITE        start pulses; payload sampled with the pulse
//   AXIL_TRANSACTION_RADDR        read address
//   AXIL_TRANSACTION_WRADDR/WRDATA/WSTRB  write address, data, byte strobes
//   AXIL_DONE_READ/_WRITE         one-cycle completion pulses
//   AXIL_TRANSACTION_RDATA        last read data (held)
//   AXIL_READ_ERR/_WRITE_ERR      last response was not OKAY (held)
//   M_AXIL_*                      AXI4-Lite master channels AW, W, B, AR, R
module axil_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    // Pipeline side
    input  logic                   AXIL_START_READ,
    input  logic                   AXIL_START_WRITE,
    input  logic [ADDR_WIDTH-1:0]  AXIL_TRANSACTION_RADDR,
    input  logic [ADDR_WIDTH-1:0]  AXIL_TRANSACTION_WRADDR,
    input  logic [BUS_WIDTH-1:0]   AXIL_TRANSACTION_WRDATA,
    input  logic [BUS_WIDTH/8-1:0] AXIL_TRANSACTION_WSTRB,
    output logic                   AXIL_DONE_READ,
    output logic                   AXIL_DONE_WRITE,
    output logic [BUS_WIDTH-1:0]   AXIL_TRANSACTION_RDATA,
    output logic                   AXIL_READ_ERR,
    output logic                   AXIL_WRITE_ERR,
    // AW channel
    output logic [ADDR_WIDTH-1:0]  M_AXIL_AWADDR,
    output logic [2:0]             M_AXIL_AWPROT,
    output logic                   M_AXIL_AWVALID,
    input  logic                   M_AXIL_AWREADY,
    // W channel
    output logic [BUS_WIDTH-1:0]   M_AXIL_WDATA,
    output logic [BUS_WIDTH/8-1:0] M_AXIL_WSTRB,
    output logic                   M_AXIL_WVALID,
    input  logic                   M_AXIL_WREADY,
    // B channel
    input  logic [1:0]             M_AXIL_BRESP,
    input  logic                   M_AXIL_BVALID,
    output logic                   M_AXIL_BREADY,
    // AR channel
    output logic [ADDR_WIDTH-1:0]  M_AXIL_ARADDR,
    output logic [2:0]             M_AXIL_ARPROT,
    output logic                   M_AXIL_ARVALID,
    input  logic                   M_AXIL_ARREADY,
    // R channel
    input  logic [BUS_WIDTH-1:0]   M_AXIL_RDATA,
    input  logic [1:0]             M_AXIL_RRESP,
    input  logic                   M_AXIL_RVALID,
    output logic                   M_AXIL_RREADY
);

    localparam int unsigned StrbWidth = BUS_WIDTH / 8;

    typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;
    typedef enum logic [1:0] {WIdle, WReq, WResp} wr_state_e;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  read_err_q, read_err_d;
    logic                  done_read_q, done_read_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_state_q  <= RIdle;
            araddr_q    <= '0;
            rdata_q     <= '0;
            read_err_q  <= 1'b0;
            done_read_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            araddr_q    <= araddr_d;
            rdata_q     <= rdata_d;
            read_err_q  <= read_err_d;
            done_read_q <= done_read_d;
        end
    end

    // ARVALID is high for the whole of RAddr and RREADY for the whole of RData,
    // so a handshake is simply READY/VALID from the slave in that state.
    always_comb begin
        rd_state_d  = rd_state_q;
        araddr_d    = araddr_q;
        rdata_d     = rdata_q;
        read_err_d  = read_err_q;
        done_read_d = 1'b0;
        unique case (rd_state_q)
            RIdle: begin
                if (AXIL_START_READ) begin
                    araddr_d   = AXIL_TRANSACTION_RADDR;
                    rd_state_d = RAddr;
                end
            end
            RAddr: begin
                if (M_AXIL_ARREADY) begin
                    rd_state_d = RData;
                end
            end
            RData: begin
                if (M_AXIL_RVALID) begin
                    rdata_d     = M_AXIL_RDATA;
                    read_err_d  = (M_AXIL_RRESP != 2'b00);
                    done_read_d = 1'b1;
                    rd_state_d  = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    always_comb begin
        M_AXIL_ARVALID = (rd_state_q == RAddr);
        M_AXIL_RREADY  = (rd_state_q == RData);
    end

    assign M_AXIL_ARADDR          = araddr_q;
    assign M_AXIL_ARPROT          = 3'b000;
    assign AXIL_DONE_READ         = done_read_q;
    assign AXIL_TRANSACTION_RDATA = rdata_q;
    assign AXIL_READ_ERR          = read_err_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  write_err_q, write_err_d;
    logic                  done_write_q, done_write_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_state_q   <= WIdle;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            write_err_q  <= 1'b0;
            done_write_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            write_err_q  <= write_err_d;
            done_write_q <= done_write_d;
        end
    end

    // AW and W complete independently; a done flag records each handshake so
    // its VALID drops while the other channel may still be waiting.
    always_comb begin
        wr_state_d   = wr_state_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        write_err_d  = write_err_q;
        done_write_d = 1'b0;
        unique case (wr_state_q)
            WIdle: begin
                if (AXIL_START_WRITE) begin
                    awaddr_d   = AXIL_TRANSACTION_WRADDR;
                    wdata_d    = AXIL_TRANSACTION_WRDATA;
                    wstrb_d    = AXIL_TRANSACTION_WSTRB;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = WReq;
                end
            end
            WReq: begin
                aw_done_d = aw_done_q | M_AXIL_AWREADY;
                w_done_d  = w_done_q | M_AXIL_WREADY;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = WResp;
                end
            end
            WResp: begin
                if (M_AXIL_BVALID) begin
                    write_err_d  = (M_AXIL_BRESP != 2'b00);
                    done_write_d = 1'b1;
                    wr_state_d   = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        M_AXIL_AWVALID = (wr_state_q == WReq) && !aw_done_q;
        M_AXIL_WVALID  = (wr_state_q == WReq) && !w_done_q;
        M_AXIL_BREADY  = (wr_state_q == WResp);
    end

    assign M_AXIL_AWADDR   = awaddr_q;
    assign M_AXIL_AWPROT   = 3'b000;
    assign M_AXIL_WDATA    = wdata_q;
    assign M_AXIL_WSTRB    = wstrb_q;
    assign AXIL_DONE_WRITE = done_write_q;
    assign AXIL_WRITE_ERR  = write_err_q;

endmodule

// File: tb/tb_axil_master.sv
// Testbench for axil_master: directed vectors, programmable-latency slave,
// queue-based scoreboard checked by an independent negedge monitor.
module tb_axil_master;

    logic        CLK;
    logic        RST_N;
    logic        AXIL_START_READ;
    logic        AXIL_START_WRITE;
    logic [31:0] AXIL_TRANSACTION_RADDR;
    logic [31:0] AXIL_TRANSACTION_WRADDR;
    logic [31:0] AXIL_TRANSACTION_WRDATA;
    logic [3:0]  AXIL_TRANSACTION_WSTRB;
    logic        AXIL_DONE_READ;
    logic        AXIL_DONE_WRITE;
    logic [31:0] AXIL_TRANSACTION_RDATA;
    logic        AXIL_READ_ERR;
    logic        AXIL_WRITE_ERR;
    logic [31:0] M_AXIL_AWADDR;
    logic [2:0]  M_AXIL_AWPROT;
    logic        M_AXIL_AWVALID;
    logic        M_AXIL_AWREADY;
    logic [31:0] M_AXIL_WDATA;
    logic [3:0]  M_AXIL_WSTRB;
    logic        M_AXIL_WVALID;
    logic        M_AXIL_WREADY;
    logic [1:0]  M_AXIL_BRESP;
    logic        M_AXIL_BVALID;
    logic        M_AXIL_BREADY;
    logic [31:0] M_AXIL_ARADDR;
    logic [2:0]  M_AXIL_ARPROT;
    logic        M_AXIL_ARVALID;
    logic        M_AXIL_ARREADY;
    logic [31:0] M_AXIL_RDATA;
    logic [1:0]  M_AXIL_RRESP;
    logic        M_AXIL_RVALID;
    logic        M_AXIL_RREADY;

    axil_master #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) dut (
        .CLK                    (CLK),
        .RST_N                  (RST_N),
        .AXIL_START_READ        (AXIL_START_READ),
        .AXIL_START_WRITE       (AXIL_START_WRITE),
        .AXIL_TRANSACTION_RADDR (AXIL_TRANSACTION_RADDR),
        .AXIL_TRANSACTION_WRADDR(AXIL_TRANSACTION_WRADDR),
        .AXIL_TRANSACTION_WRDATA(AXIL_TRANSACTION_WRDATA),
        .AXIL_TRANSACTION_WSTRB (AXIL_TRANSACTION_WSTRB),
        .AXIL_DONE_READ         (AXIL_DONE_READ),
        .AXIL_DONE_WRITE        (AXIL_DONE_WRITE),
        .AXIL_TRANSACTION_RDATA (AXIL_TRANSACTION_RDATA),
        .AXIL_READ_ERR          (AXIL_READ_ERR),
        .AXIL_WRITE_ERR         (AXIL_WRITE_ERR),
        .M_AXIL_AWADDR          (M_AXIL_AWADDR),
        .M_AXIL_AWPROT          (M_AXIL_AWPROT),
        .M_AXIL_AWVALID         (M_AXIL_AWVALID),
        .M_AXIL_AWREADY         (M_AXIL_AWREADY),
        .M_AXIL_WDATA           (M_AXIL_WDATA),
        .M_AXIL_WSTRB           (M_AXIL_WSTRB),
        .M_AXIL_WVALID          (M_AXIL_WVALID),
        .M_AXIL_WREADY          (M_AXIL_WREADY),
        .M_AXIL_BRESP           (M_AXIL_BRESP),
        .M_AXIL_BVALID          (M_AXIL_BVALID),
        .M_AXIL_BREADY          (M_AXIL_BREADY),
        .M_AXIL_ARADDR          (M_AXIL_ARADDR),
        .M_AXIL_ARPROT          (M_AXIL_ARPROT),
        .M_AXIL_ARVALID         (M_AXIL_ARVALID),
        .M_AXIL_ARREADY         (M_AXIL_ARREADY),
        .M_AXIL_RDATA           (M_AXIL_RDATA),
        .M_AXIL_RRESP           (M_AXIL_RRESP),
        .M_AXIL_RVALID          (M_AXIL_RVALID),
        .M_AXIL_RREADY          (M_AXIL_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- counters and scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_done_rd = 0;
    int n_done_wr = 0;

    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];   // {strb, data}
    logic [32:0] exp_rd[$];  // {err, data}
    logic        exp_wr[$];  // err

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT presented output with no expected entry queued", name);
    endtask

    // ---------------- slave model ----------------
    int ar_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    int ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt;
    logic r_pend, b_pend, aw_seen, w_seen;
    logic [31:0] rdata_val = '0;
    logic [1:0]  rresp_val = '0;
    logic [1:0]  bresp_val = '0;

    assign M_AXIL_ARREADY = M_AXIL_ARVALID && (ar_cnt >= ar_wait);
    assign M_AXIL_AWREADY = M_AXIL_AWVALID && (aw_cnt >= aw_wait);
    assign M_AXIL_WREADY  = M_AXIL_WVALID && (w_cnt >= w_wait);
    assign M_AXIL_RVALID  = r_pend && (r_cnt >= r_wait);
    assign M_AXIL_BVALID  = b_pend && (b_cnt >= b_wait);
    assign M_AXIL_RDATA   = rdata_val;
    assign M_AXIL_RRESP   = rresp_val;
    assign M_AXIL_BRESP   = bresp_val;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
        end else begin
            ar_cnt <= (M_AXIL_ARVALID && !M_AXIL_ARREADY) ? ar_cnt + 1 : 0;
            aw_cnt <= (M_AXIL_AWVALID && !M_AXIL_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXIL_WVALID && !M_AXIL_WREADY) ? w_cnt + 1 : 0;
            if (M_AXIL_ARVALID && M_AXIL_ARREADY) begin
                r_pend <= 1'b1;
                r_cnt  <= 0;
            end else if (r_pend) begin
                if (M_AXIL_RVALID && M_AXIL_RREADY) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (M_AXIL_AWVALID && M_AXIL_AWREADY) aw_seen <= 1'b1;
            if (M_AXIL_WVALID && M_AXIL_WREADY) w_seen <= 1'b1;
            if (!b_pend && (aw_seen || (M_AXIL_AWVALID && M_AXIL_AWREADY))
                        && (w_seen || (M_AXIL_WVALID && M_AXIL_WREADY))) begin
                b_pend  <= 1'b1;
                b_cnt   <= 0;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end else if (b_pend) begin
                if (M_AXIL_BVALID && M_AXIL_BREADY) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] m_a;
    logic [35:0] m_w;
    logic [32:0] m_r;
    logic        m_b;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (M_AXIL_ARVALID && M_AXIL_ARREADY) begin
                if (exp_ar.size() == 0) unexpected("ar_handshake");
                else begin
                    m_a = exp_ar.pop_front();
                    check("ar_addr", 64'(M_AXIL_ARADDR), 64'(m_a));
                    check("ar_prot", 64'(M_AXIL_ARPROT), 64'(3'b000));
                end
            end
            if (M_AXIL_AWVALID && M_AXIL_AWREADY) begin
                if (exp_aw.size() == 0) unexpected("aw_handshake");
                else begin
                    m_a = exp_aw.pop_front();
                    check("aw_addr", 64'(M_AXIL_AWADDR), 64'(m_a));
                    check("aw_prot", 64'(M_AXIL_AWPROT), 64'(3'b000));
                end
            end
            if (M_AXIL_WVALID && M_AXIL_WREADY) begin
                if (exp_w.size() == 0) unexpected("w_handshake");
                else begin
                    m_w = exp_w.pop_front();
                    check("w_data", 64'(M_AXIL_WDATA), 64'(m_w[31:0]));
                    check("w_strb", 64'(M_AXIL_WSTRB), 64'(m_w[35:32]));
                end
            end
            if (AXIL_DONE_READ) begin
                n_done_rd++;
                if (exp_rd.size() == 0) unexpected("done_read");
                else begin
                    m_r = exp_rd.pop_front();
                    check("rd_data", 64'(AXIL_TRANSACTION_RDATA), 64'(m_r[31:0]));
                    check("rd_err", 64'(AXIL_READ_ERR), 64'(m_r[32]));
                end
            end
            if (AXIL_DONE_WRITE) begin
                n_done_wr++;
                if (exp_wr.size() == 0) unexpected("done_write");
                else begin
                    m_b = exp_wr.pop_front();
                    check("wr_err", 64'(AXIL_WRITE_ERR), 64'(m_b));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    int d0;

    initial begin
        RST_N = 1'b0;
        AXIL_START_READ = 1'b0;
        AXIL_START_WRITE = 1'b0;
        AXIL_TRANSACTION_RADDR = '0;
        AXIL_TRANSACTION_WRADDR = '0;
        AXIL_TRANSACTION_WRDATA = '0;
        AXIL_TRANSACTION_WSTRB = '0;
        #3;
        check("rst_arvalid", 64'(M_AXIL_ARVALID), 64'(0));
        check("rst_awvalid", 64'(M_AXIL_AWVALID), 64'(0));
        check("rst_wvalid", 64'(M_AXIL_WVALID), 64'(0));
        check("rst_bready", 64'(M_AXIL_BREADY), 64'(0));
        check("rst_rready", 64'(M_AXIL_RREADY), 64'(0));
        check("rst_done", 64'({AXIL_DONE_READ, AXIL_DONE_WRITE}), 64'(0));
        check("rst_rdata", 64'(AXIL_TRANSACTION_RDATA), 64'(0));
        check("rst_errs", 64'({AXIL_READ_ERR, AXIL_WRITE_ERR}), 64'(0));
        tick; tick;
        RST_N = 1'b1;
        tick;

        // Zero-wait read
        rdata_val = 32'hDEAD_BEEF; rresp_val = 2'b00;
        exp_ar.push_back(32'h1000_0004);
        exp_rd.push_back({1'b0, 32'hDEAD_BEEF});
        d0 = n_done_rd;
        AXIL_START_READ = 1'b1; AXIL_TRANSACTION_RADDR = 32'h1000_0004;
        tick; AXIL_START_READ = 1'b0;                                 // cycle 1
        check("zr_arvalid_c1", 64'(M_AXIL_ARVALID), 64'(1));
        check("zr_araddr_c1", 64'(M_AXIL_ARADDR), 64'(32'h1000_0004));
        tick;                                                          // cycle 2
        check("zr_rready_c2", 64'(M_AXIL_RREADY), 64'(1));
        check("zr_done_c2", 64'(AXIL_DONE_READ), 64'(0));
        tick;                                                          // cycle 3
        check("zr_done_c3", 64'(AXIL_DONE_READ), 64'(1));
        check("zr_rdata_c3", 64'(AXIL_TRANSACTION_RDATA), 64'(32'hDEAD_BEEF));
        tick;                                                          // cycle 4
        check("zr_done_c4", 64'(AXIL_DONE_READ), 64'(0));
        check("zr_done_count", 64'(n_done_rd - d0), 64'(1));

        // Skewed write: W at cycle 1, AW at cycle 4, B at cycle 6
        aw_wait = 3; w_wait = 0; b_wait = 1; bresp_val = 2'b10;
        exp_aw.push_back(32'h2000_0010);
        exp_w.push_back({4'hF, 32'h1234_5678});
        exp_wr.push_back(1'b1);
        AXIL_START_WRITE = 1'b1; AXIL_TRANSACTION_WRADDR = 32'h2000_0010;
        AXIL_TRANSACTION_WRDATA = 32'h1234_5678; AXIL_TRANSACTION_WSTRB = 4'hF;
        tick; AXIL_START_WRITE = 1'b0;                                // cycle 1
        check("sw_vld_c1", 64'({M_AXIL_AWVALID, M_AXIL_WVALID}), 64'(2'b11));
        tick;                                                          // cycle 2
        check("sw_vld_c2", 64'({M_AXIL_AWVALID, M_AXIL_WVALID}), 64'(2'b10));
        tick;                                                          // cycle 3
        check("sw_vld_c3", 64'({M_AXIL_AWVALID, M_AXIL_WVALID}), 64'(2'b10));
        tick;                                                          // cycle 4
        check("sw_vld_c4", 64'({M_AXIL_AWVALID, M_AXIL_WVALID}), 64'(2'b10));
        check("sw_awaddr_c4", 64'(M_AXIL_AWADDR), 64'(32'h2000_0010));
        tick;                                                          // cycle 5
        check("sw_awvalid_c5", 64'(M_AXIL_AWVALID), 64'(0));
        check("sw_bready_c5", 64'(M_AXIL_BREADY), 64'(1));
        tick;                                                          // cycle 6
        check("sw_done_c6", 64'(AXIL_DONE_WRITE), 64'(0));
        tick;                                                          // cycle 7
        check("sw_done_c7", 64'(AXIL_DONE_WRITE), 64'(1));
        check("sw_err_c7", 64'(AXIL_WRITE_ERR), 64'(1));
        tick;                                                          // cycle 8
        check("sw_done_c8", 64'(AXIL_DONE_WRITE), 64'(0));
        aw_wait = 0; b_wait = 0; bresp_val = 2'b00;

        // AR backpressure, second start ignored while busy
        ar_wait = 5; rdata_val = 32'hCAFE_F00D; rresp_val = 2'b11;
        exp_ar.push_back(32'h3000_0008);
        exp_rd.push_back({1'b1, 32'hCAFE_F00D});
        d0 = n_done_rd;
        AXIL_START_READ = 1'b1; AXIL_TRANSACTION_RADDR = 32'h3000_0008;
        for (int c = 1; c <= 6; c++) begin
            tick;
            AXIL_START_READ = (c == 2);
            AXIL_TRANSACTION_RADDR = (c == 2) ? 32'hBAD0_0000 : 32'h0;
            check("bp_arvalid", 64'(M_AXIL_ARVALID), 64'(1));
            check("bp_araddr", 64'(M_AXIL_ARADDR), 64'(32'h3000_0008));
        end
        repeat (6) tick;
        check("bp_done_count", 64'(n_done_rd - d0), 64'(1));
        check("bp_idle_after", 64'(M_AXIL_ARVALID), 64'(0));
        ar_wait = 0;

        // Concurrent read and write, zero-wait slave
        rdata_val = 32'h5555_AAAA; rresp_val = 2'b00; bresp_val = 2'b00;
        exp_ar.push_back(32'h4000_1000);
        exp_rd.push_back({1'b0, 32'h5555_AAAA});
        exp_aw.push_back(32'h4000_0000);
        exp_w.push_back({4'h3, 32'hA5A5_5A5A});
        exp_wr.push_back(1'b0);
        AXIL_START_READ = 1'b1; AXIL_TRANSACTION_RADDR = 32'h4000_1000;
        AXIL_START_WRITE = 1'b1; AXIL_TRANSACTION_WRADDR = 32'h4000_0000;
        AXIL_TRANSACTION_WRDATA = 32'hA5A5_5A5A; AXIL_TRANSACTION_WSTRB = 4'h3;
        tick; AXIL_START_READ = 1'b0; AXIL_START_WRITE = 1'b0;       // cycle 1
        check("cc_vld_c1", 64'({M_AXIL_ARVALID, M_AXIL_AWVALID, M_AXIL_WVALID}), 64'(3'b111));
        tick; tick;                                                    // cycle 3
        check("cc_done_c3", 64'({AXIL_DONE_READ, AXIL_DONE_WRITE}), 64'(2'b11));
        check("cc_wr_err_c3", 64'(AXIL_WRITE_ERR), 64'(0));
        tick;

        // Back-to-back reads: new start in the DONE cycle
        rdata_val = 32'h1111_1111;
        exp_ar.push_back(32'h5000_0000);
        exp_rd.push_back({1'b0, 32'h1111_1111});
        AXIL_START_READ = 1'b1; AXIL_TRANSACTION_RADDR = 32'h5000_0000;
        tick; AXIL_START_READ = 1'b0;                                 // cycle 1
        tick; tick;                                                    // cycle 3
        check("bb_done1_c3", 64'(AXIL_DONE_READ), 64'(1));
        rdata_val = 32'h2222_2222;
        exp_ar.push_back(32'h5000_0004);
        exp_rd.push_back({1'b0, 32'h2222_2222});
        AXIL_START_READ = 1'b1; AXIL_TRANSACTION_RADDR = 32'h5000_0004;
        tick; AXIL_START_READ = 1'b0;                                 // cycle 4
        check("bb_arvalid_c4", 64'(M_AXIL_ARVALID), 64'(1));
        check("bb_araddr_c4", 64'(M_AXIL_ARADDR), 64'(32'h5000_0004));
        check("bb_rdata_c4", 64'(AXIL_TRANSACTION_RDATA), 64'(32'h1111_1111));
        tick;                                                          // cycle 5
        check("bb_rdata_c5", 64'(AXIL_TRANSACTION_RDATA), 64'(32'h1111_1111));
        tick;                                                          // cycle 6
        check("bb_done2_c6", 64'(AXIL_DONE_READ), 64'(1));
        check("bb_rdata_c6", 64'(AXIL_TRANSACTION_RDATA), 64'(32'h2222_2222));
        tick;

        // Reset while waiting for B
        b_wait = 10;
        exp_aw.push_back(32'h6000_0000);
        exp_w.push_back({4'hF, 32'h0F0F_0F0F});
        d0 = n_done_wr;
        AXIL_START_WRITE = 1'b1; AXIL_TRANSACTION_WRADDR = 32'h6000_0000;
        AXIL_TRANSACTION_WRDATA = 32'h0F0F_0F0F; AXIL_TRANSACTION_WSTRB = 4'hF;
        tick; AXIL_START_WRITE = 1'b0;                                // cycle 1
        tick;                                                          // cycle 2
        check("rm_bready_c2", 64'(M_AXIL_BREADY), 64'(1));
        tick;                                                          // cycle 3
        RST_N = 1'b0;
        #1;
        check("rm_bready", 64'(M_AXIL_BREADY), 64'(0));
        check("rm_valids",
              64'({M_AXIL_ARVALID, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_RREADY}), 64'(0));
        check("rm_rdata", 64'(AXIL_TRANSACTION_RDATA), 64'(0));
        check("rm_errs", 64'({AXIL_READ_ERR, AXIL_WRITE_ERR}), 64'(0));
        tick; tick;
        RST_N = 1'b1;
        b_wait = 0; bresp_val = 2'b01;
        repeat (3) tick;
        check("rm_no_done", 64'(n_done_wr - d0), 64'(0));

        // Fresh write after reset
        exp_aw.push_back(32'h7000_0020);
        exp_w.push_back({4'h8, 32'h8765_4321});
        exp_wr.push_back(1'b1);
        AXIL_START_WRITE = 1'b1; AXIL_TRANSACTION_WRADDR = 32'h7000_0020;
        AXIL_TRANSACTION_WRDATA = 32'h8765_4321; AXIL_TRANSACTION_WSTRB = 4'h8;
        tick; AXIL_START_WRITE = 1'b0;                                // cycle 1
        tick;                                                          // cycle 2
        check("fw_done_c2", 64'(AXIL_DONE_WRITE), 64'(0));
        tick;                                                          // cycle 3
        check("fw_done_c3", 64'(AXIL_DONE_WRITE), 64'(1));
        check("fw_err_c3", 64'(AXIL_WRITE_ERR), 64'(1));
        repeat (3) tick;

        // Drain checks
        check("sb_ar_left", 64'(exp_ar.size()), 64'(0));
        check("sb_aw_left", 64'(exp_aw.size()), 64'(0));
        check("sb_w_left", 64'(exp_w.size()), 64'(0));
        check("sb_rd_left", 64'(exp_rd.size()), 64'(0));
        check("sb_wr_left", 64'(exp_wr.size()), 64'(0));
        check("total_done_rd", 64'(n_done_rd), 64'(5));
        check("total_done_wr", 64'(n_done_wr), 64'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_master.md
# axil_master

AXI4-Lite master engine that sits directly downstream of the pipeline's AXI-Lite request generator. It accepts single-cycle read and write start pulses with the address, data and strobe for the transaction, and drives the five AXI4-Lite channels. It returns a one-cycle done pulse, read data and response error flags to the pipeline. Read and write paths are independent FSMs and may be in flight concurrently.

## Interface
- ADDR_WIDTH, 32, address width of requests and AXI AW/AR channels
- BUS_WIDTH, 32, data width; strobe width is BUS_WIDTH/8
- Clocking/reset: one clock; reset is asynchronous and active-low
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- AXIL_START_READ  in  1  single-cycle read request pulse
- AXIL_START_WRITE  in  1  single-cycle write request pulse
- AXIL_TRANSACTION_RADDR  in  ADDR_WIDTH  read address, sampled with START_READ
- AXIL_TRANSACTION_WRADDR  in  ADDR_WIDTH  write address, sampled with START_WRITE
- AXIL_TRANSACTION_WRDATA  in  BUS_WIDTH  write data, sampled with START_WRITE
- AXIL_TRANSACTION_WSTRB  in  BUS_WIDTH/8  byte strobes, sampled with START_WRITE
- AXIL_DONE_READ  out  1  one-cycle pulse: read response accepted
- AXIL_DONE_WRITE  out  1  one-cycle pulse: write response accepted
- AXIL_TRANSACTION_RDATA  out  BUS_WIDTH  last read data, held until next read completes
- AXIL_READ_ERR  out  1  RRESP of last read != OKAY, held like RDATA
- AXIL_WRITE_ERR  out  1  BRESP of last write != OKAY, held until next write completes
- M_AXIL_AWADDR / AWPROT / AWVALID  out  ADDR_WIDTH / 3 / 1; AWREADY in 1
- M_AXIL_WDATA / WSTRB / WVALID  out  BUS_WIDTH / BUS_WIDTH/8 / 1; WREADY in 1
- M_AXIL_BRESP in 2; BVALID in 1; BREADY out 1
- M_AXIL_ARADDR / ARPROT / ARVALID  out  ADDR_WIDTH / 3 / 1; ARREADY in 1
- M_AXIL_RDATA in BUS_WIDTH; RRESP in 2; RVALID in 1; RREADY out 1

## Operation
- Reset value of every output is 0. The async assert forces all VALID/READY low immediately. Deassertion is synchronous to CLK.
- AWPROT and ARPROT are constant 3'b000.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE + START_READ: latch RADDR into ARADDR, set ARVALID, go to R_ADDR.
  - R_ADDR: hold ARVALID and ARADDR stable until ARVALID&&ARREADY. Then drop ARVALID, set RREADY, go to R_DATA.
  - R_DATA: on RVALID&&RREADY, register RDATA and READ_ERR=(RRESP!=2'b00), drop RREADY, pulse DONE_READ next cycle, go to R_IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE + START_WRITE: latch WRADDR/WRDATA/WSTRB, set AWVALID and WVALID, clear aw_done/w_done, go to W_REQ.
  - W_REQ: AW and W handshake independently, in either order or in the same cycle. Each VALID drops the cycle after its own handshake and sets its done flag. When both flags are set, including handshakes in the same cycle, set BREADY and go to W_RESP.
  - W_RESP: on BVALID&&BREADY, WRITE_ERR=(BRESP!=2'b00), drop BREADY, pulse DONE_WRITE next cycle, go to W_IDLE.
- A START while its FSM is not in IDLE is ignored (upstream holds a pending flag until DONE). The channel payload is not changed.
- Read and write starts in the same cycle are both accepted. DONE_READ and DONE_WRITE may pulse in the same cycle.
- AXI rule: a VALID, once asserted, never drops before its handshake, and its payload is stable during that time.

## Timing
- START at cycle 0 -> ARVALID/AWVALID/WVALID high at cycle 1 (registered).
- Minimum read latency (zero-wait slave):
  - ARREADY=1 at cycle 1.
  - RREADY high and RVALID=1 at cycle 2.
  - DONE_READ high at cycle 3, with RDATA valid the same cycle.
- Minimum write latency:
  - AW and W handshake at cycle 1.
  - BREADY high and BVALID at cycle 2.
  - DONE_WRITE high at cycle 3.
- DONE pulses are exactly one cycle wide. The earliest new START is accepted in the DONE cycle, because the FSM is already IDLE.
- Each ready-wait cycle from the slave extends latency by one cycle, with no upper bound and no timeout.
- Reset mid-transaction: FSMs return to IDLE and no DONE pulse is issued. RDATA and both ERR flags go to 0.

## Test plan
- Zero-wait read: START_READ, RADDR=0x1000_0004; slave returns RDATA=0xDEAD_BEEF, RRESP=0 -> ARADDR=0x1000_0004 at cycle 1, DONE_READ at cycle 3 only, RDATA=0xDEADBEEF, READ_ERR=0.
- Skewed write: WRDATA=0x1234_5678, WSTRB=0xF; WREADY at cycle 1, AWREADY at cycle 4, BVALID at cycle 6 with BRESP=2'b10 -> WVALID low from cycle 2, AWVALID held until cycle 4, DONE_WRITE at cycle 7, WRITE_ERR=1.
- Backpressure: ARREADY low for 5 cycles -> ARVALID and ARADDR stable throughout; a second START_READ issued during the wait is ignored; exactly one DONE_READ.
- Concurrent: START_READ and START_WRITE in the same cycle, zero-wait slave -> both DONE pulses at cycle 3, both channel payloads correct.
- Back-to-back: new START_READ in the DONE_READ cycle -> second ARVALID the next cycle; RDATA updates only at the second DONE.
- Reset mid-op: assert RST_N=0 while in W_RESP -> BREADY and all VALIDs 0 immediately, no DONE_WRITE; after release, a fresh write completes normally.
